rf_wb_arbiter: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 32×32 register file. Several writeback sources (ALU, load unit, multi-cycle mul/div) share the file's single write port. The block grants one source per cycle with round-robin priority and drives the register file's write address, data and enable from registers. It also keeps a per-register pending mask so issue logic can stall readers of registers that still have an outstanding write.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rf_wb_arbiter.sv | 110 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path: widths, address/data
// typedefs and the writeback request record.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    typedef struct packed {
        logic     valid;
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching upward modulo N.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_idx,
    output logic         any_gnt
);

    logic [3:0] cand_s;
    logic       hit_s;

    // Walk offsets 0..N-1 from ptr; the first valid candidate takes the grant.
    always_comb begin
        gnt     = '0;
        gnt_idx = 3'd0;
        any_gnt = 1'b0;
        cand_s  = 4'd0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand_s = {1'b0, ptr} + 4'(i);
            cand_s = (cand_s >= 4'(N)) ? (cand_s - 4'(N)) : cand_s;
            for (int k = 0; k < N; k++) begin
                hit_s   = !any_gnt && req[k] && (cand_s == 4'(k));
                gnt[k]  = gnt[k] | hit_s;
                gnt_idx = hit_s ? 3'(k) : gnt_idx;
                any_gnt = any_gnt | hit_s;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with registered write outputs and a
// per-register pending-write scoreboard for issue-side stalls.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NREQ*DATA_W-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic                     i_issue_valid,
    input  logic [ADDR_W-1:0]        i_issue_rd,
    output logic [ADDR_W-1:0]        o_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_wren,
    output logic [RF_NUM_REGS-1:0]   o_pending
);

    wb_req_t                 req_s [NREQ];
    logic [NREQ-1:0]         gnt_s;
    logic [2:0]              gnt_idx_s;
    logic                    any_gnt_s;

    logic [2:0]              rr_ptr_q,  rr_ptr_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic                    rd_wren_q, rd_wren_d;
    logic [RF_NUM_REGS-1:0]  pending_q, pending_d;

    // Unpack the flat request buses into records.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_s[k].valid = i_req_valid[k];
            req_s[k].addr  = rf_addr_t'(i_req_addr[k*ADDR_W +: ADDR_W]);
            req_s[k].data  = rf_data_t'(i_req_data[k*DATA_W +: DATA_W]);
        end
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (i_req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any_gnt (any_gnt_s)
    );

    // Grant is suppressed during reset so no requester believes it transferred.
    always_comb begin
        o_req_ready = i_rst ? '0 : gnt_s;
    end

    // Next-state: granted write capture, pointer advance, scoreboard update.
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        for (int k = 0; k < NREQ; k++) begin
            rd_addr_d = gnt_s[k] ? ADDR_W'(req_s[k].addr) : rd_addr_d;
            rd_data_d = gnt_s[k] ? DATA_W'(req_s[k].data) : rd_data_d;
        end
        rd_wren_d = any_gnt_s && (rd_addr_d != '0);

        if (any_gnt_s) begin
            rr_ptr_d = (gnt_idx_s == 3'(NREQ-1)) ? 3'd0 : (gnt_idx_s + 3'd1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // Clear first so a same-cycle issue to the same register re-sets it.
        pending_d = pending_q;
        if (rd_wren_q) begin
            pending_d[rd_addr_q] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (i_issue_valid && (i_issue_rd != '0)) begin
            pending_d[i_issue_rd] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; asynchronous reset discards any in-flight write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q  <= 3'd0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_wren_q <= 1'b0;
            pending_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rd_wren_q <= rd_wren_d;
            pending_q <= pending_d;
        end
    end

    assign o_rd_addr = rd_addr_q;
    assign o_rd_data = rd_data_q;
    assign o_rd_wren = rd_wren_q;
    assign o_pending = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*ADDR_W-1:0] i_req_addr;
    logic [NREQ*DATA_W-1:0] i_req_data;
    logic [NREQ-1:0]        o_req_ready;
    logic                   i_issue_valid;
    logic [ADDR_W-1:0]      i_issue_rd;
    logic [ADDR_W-1:0]      o_rd_addr;
    logic [DATA_W-1:0]      o_rd_data;
    logic                   o_rd_wren;
    logic [31:0]            o_pending;

    int tests_run    = 0;
    int tests_failed = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_req_ready   (o_req_ready),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_wren     (o_rd_wren),
        .o_pending     (o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        i_req_valid[k]               = v;
        i_req_addr[k*ADDR_W +: ADDR_W] = a;
        i_req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic check_out(input string tag, input logic wren, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        check_eq({tag, ".wren"}, 64'(o_rd_wren), 64'(wren));
        check_eq({tag, ".addr"}, 64'(o_rd_addr), 64'(a));
        check_eq({tag, ".data"}, 64'(o_rd_data), 64'(d));
    endtask

    initial begin
        i_rst         = 1'b1;
        i_req_valid   = '0;
        i_req_addr    = '0;
        i_req_data    = '0;
        i_issue_valid = 1'b0;
        i_issue_rd    = '0;

        // Reset state: ready suppressed even with everyone valid.
        tick();
        set_req(1, 1'b1, 5'd4, 32'h1111_1111);
        #1;
        check_eq("rst.ready", 64'(o_req_ready), 64'd0);
        check_out("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.pending", 64'(o_pending), 64'd0);
        tick();
        i_rst = 1'b0;
        set_req(1, 1'b0, 5'd0, 32'd0);

        // Round-robin from pointer 0 with all three requesters valid.
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 5'(k + 1), 32'hA000_0000 + 32'(k));
        #1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr.ready%0d", i), 64'(o_req_ready), 64'(3'b001 << (i % 3)));
            tick();
            check_out($sformatf("rr.out%0d", i), 1'b1, 5'((i % 3) + 1), 32'hA000_0000 + 32'(i % 3));
        end
        i_req_valid = '0;

        // Single source; pointer is back at 0.
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check_eq("single.ready", 64'(o_req_ready), 64'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        check_out("single", 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check_eq("idle.ready", 64'(o_req_ready), 64'd0);
        tick();
        check_out("idle.hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

        // Write to x0 with a simultaneous issue to x0.
        set_req(2, 1'b1, 5'd0, 32'h0000_1234);
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd0;
        #1;
        check_eq("x0.ready", 64'(o_req_ready), 64'b100);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        i_issue_valid = 1'b0;
        check_out("x0", 1'b0, 5'd0, 32'h0000_1234);
        check_eq("x0.pending", 64'(o_pending), 64'd0);

        // Pointer wrapped to 0: req0 wins over req1.
        set_req(0, 1'b1, 5'd6, 32'h6666_0000);
        set_req(1, 1'b1, 5'd6, 32'h6666_0001);
        #1;
        check_eq("wrap.ready", 64'(o_req_ready), 64'b001);
        tick();
        i_req_valid = '0;
        check_out("wrap", 1'b1, 5'd6, 32'h6666_0000);

        // Scoreboard: issue rd 7 in cycle 0, req1 granted in cycle 3 (ptr=1).
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd7;
        tick();
        i_issue_valid = 1'b0;
        check_eq("sb.c1", 64'(o_pending), 64'(32'h1 << 7));
        tick();
        tick();
        set_req(1, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        check_eq("sb.ready", 64'(o_req_ready), 64'b010);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        check_out("sb.c4", 1'b1, 5'd7, 32'h0000_0077);
        check_eq("sb.c4.pending", 64'(o_pending), 64'(32'h1 << 7));
        tick();
        check_eq("sb.c5.pending", 64'(o_pending), 64'd0);

        // Set/clear collision on rd 9 (ptr=2, only req0 valid).
        set_req(0, 1'b1, 5'd9, 32'h9999_0000);
        #1;
        check_eq("col.ready", 64'(o_req_ready), 64'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        check_eq("col.wren", 64'(o_rd_wren), 64'd1);
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd9;
        tick();
        i_issue_valid = 1'b0;
        check_eq("col.set_wins", 64'(o_pending), 64'(32'h1 << 9));
        set_req(1, 1'b1, 5'd9, 32'h9999_0001);
        #1;
        check_eq("col2.ready", 64'(o_req_ready), 64'b010);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        check_out("col2", 1'b1, 5'd9, 32'h9999_0001);
        tick();
        check_eq("col2.clear", 64'(o_pending), 64'd0);

        // Mid-operation asynchronous reset with an in-flight write and a pending bit.
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd12;
        set_req(1, 1'b1, 5'd3, 32'h3333_3333);
        tick();
        i_issue_valid = 1'b0;
        check_out("pre_rst", 1'b1, 5'd3, 32'h3333_3333);
        check_eq("pre_rst.pending", 64'(o_pending), 64'(32'h1 << 12));
        #2;
        i_rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 5'd0, 32'd0);
        check_eq("async_rst.pending", 64'(o_pending), 64'd0);
        check_eq("async_rst.ready", 64'(o_req_ready), 64'd0);
        tick();
        i_rst = 1'b0;
        set_req(0, 1'b1, 5'd8, 32'h8888_8888);
        #1;
        check_eq("post_rst.ready", 64'(o_req_ready), 64'b001);
        tick();
        i_req_valid = '0;
        check_out("post_rst", 1'b1, 5'd8, 32'h8888_8888);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
